// File: rtl/jtag_gpio_sampler_if.sv
// TAP-side bundle of the JTAG pad sampler: strobes and captured pins go to the TAP, and TDO comes back.
// The master modport is the sampler and the slave modport is the clock-enabled TAP.
interface jtag_gpio_sampler_if;
    logic tck_rise;
    logic tck_fall;
    logic TMS;
    logic TDI;
    logic TRST;
    logic TDO;
    logic DRV_TDO;

    modport master (
        output tck_rise, tck_fall, TMS, TDI, TRST,
        input  TDO, DRV_TDO
    );

    modport slave (
        input  tck_rise, tck_fall, TMS, TDI, TRST,
        output TDO, DRV_TDO
    );
endinterface

// File: rtl/jtag_gpio_sampler.sv
// Oversampling JTAG pad adapter: synchronises the pads, glitch-filters TCK into rise/fall strobes,
// stretches TRST and registers TDO. Optional glitch counter: define JTAG_GPIO_GLITCH_CNT_EN.
module jtag_gpio_sampler #(
    parameter int SYNC_STAGES = 2,
    parameter int FILTER_LEN  = 3,
    parameter int TRST_HOLD   = 4
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       io_pins_TCK_i_ival,
    input  logic       io_pins_TMS_i_ival,
    input  logic       io_pins_TDI_i_ival,
    input  logic       io_pins_TRST_n_i_ival,
    output logic [3:0] io_pins_in_o_oval,
    output logic [3:0] io_pins_in_o_oe,
    output logic [3:0] io_pins_in_o_ie,
    output logic [3:0] io_pins_in_o_pue,
    output logic [3:0] io_pins_in_o_ds,
    output logic       io_pins_TDO_o_oval,
    output logic       io_pins_TDO_o_oe,
    output logic       io_pins_TDO_o_ie,
    output logic       io_pins_TDO_o_pue,
    output logic       io_pins_TDO_o_ds,
`ifdef JTAG_GPIO_GLITCH_CNT_EN
    output logic [7:0] io_glitch_cnt,
`endif
    jtag_gpio_sampler_if.master io_jtag
);

    localparam int CW = $clog2(FILTER_LEN + 1);
    localparam int HW = $clog2(TRST_HOLD + 1);
    localparam logic [CW-1:0] CNT_LAST  = CW'(FILTER_LEN - 1);
    localparam logic [HW-1:0] HOLD_INIT = HW'(TRST_HOLD);
    // Idle pad levels, ordered {TRST_n, TDI, TMS, TCK}
    localparam logic [3:0] PAD_IDLE = 4'b1110;

    logic [3:0] pad_raw;
    logic [3:0] sync_cur;
    logic       trst_n_nxt;

    assign pad_raw = {io_pins_TRST_n_i_ival, io_pins_TDI_i_ival, io_pins_TMS_i_ival, io_pins_TCK_i_ival};

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_pad
            logic [SYNC_STAGES-1:0] chain_q;
            always_ff @(posedge clock) begin
                if (reset) begin
                    chain_q <= {SYNC_STAGES{PAD_IDLE[gi]}};
                end else begin
                    chain_q <= {chain_q[SYNC_STAGES-2:0], pad_raw[gi]};
                end
            end
            assign sync_cur[gi] = chain_q[SYNC_STAGES-1];
            // TRST_n's next synced value lets the strobe gate line up with the registered TRST
            if (gi == 3) begin : g_trst_look
                assign trst_n_nxt = chain_q[SYNC_STAGES-2];
            end
        end
    endgenerate

    logic          tck_filt_q, tck_filt_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          tck_toggle;
    logic [HW-1:0] hold_q, hold_d;
    logic          trst_q, trst_d;
    logic          rise_q, rise_d;
    logic          fall_q, fall_d;
    logic          tms_q, tms_d;
    logic          tdi_q, tdi_d;
    logic          tdo_oval_q, tdo_oval_d;
    logic          tdo_oe_q, tdo_oe_d;

    always_comb begin
        tck_filt_d = tck_filt_q;
        cnt_d      = '0;
        tck_toggle = 1'b0;
        if (sync_cur[0] != tck_filt_q) begin
            if (cnt_q == CNT_LAST) begin
                tck_toggle = 1'b1;
                tck_filt_d = ~tck_filt_q;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_comb begin
        hold_d = hold_q;
        if (!sync_cur[3]) begin
            hold_d = HOLD_INIT;
        end else if (hold_q != '0) begin
            hold_d = hold_q - 1'b1;
        end
        trst_d     = !trst_n_nxt || (hold_d != '0);
        rise_d     = tck_toggle && !tck_filt_q && !trst_d;
        fall_d     = tck_toggle && tck_filt_q && !trst_d;
        tms_d      = rise_d ? sync_cur[1] : tms_q;
        tdi_d      = rise_d ? sync_cur[2] : tdi_q;
        tdo_oval_d = fall_q ? io_jtag.TDO : tdo_oval_q;
        tdo_oe_d   = trst_d ? 1'b0 : (fall_q ? io_jtag.DRV_TDO : tdo_oe_q);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            tck_filt_q <= 1'b0;
            cnt_q      <= '0;
            hold_q     <= HOLD_INIT;
            trst_q     <= 1'b1;
            rise_q     <= 1'b0;
            fall_q     <= 1'b0;
            tms_q      <= 1'b1;
            tdi_q      <= 1'b1;
            tdo_oval_q <= 1'b0;
            tdo_oe_q   <= 1'b0;
        end else begin
            tck_filt_q <= tck_filt_d;
            cnt_q      <= cnt_d;
            hold_q     <= hold_d;
            trst_q     <= trst_d;
            rise_q     <= rise_d;
            fall_q     <= fall_d;
            tms_q      <= tms_d;
            tdi_q      <= tdi_d;
            tdo_oval_q <= tdo_oval_d;
            tdo_oe_q   <= tdo_oe_d;
        end
    end

`ifdef JTAG_GPIO_GLITCH_CNT_EN
    logic [7:0] glitch_q, glitch_d;

    // A streak that collapses back to the filtered level before acceptance is a rejected glitch
    always_comb begin
        glitch_d = glitch_q;
        if ((sync_cur[0] == tck_filt_q) && (cnt_q != '0) && (glitch_q != 8'hFF)) begin
            glitch_d = glitch_q + 8'd1;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            glitch_q <= 8'd0;
        end else begin
            glitch_q <= glitch_d;
        end
    end

    assign io_glitch_cnt = glitch_q;
`endif

    assign io_jtag.tck_rise = rise_q;
    assign io_jtag.tck_fall = fall_q;
    assign io_jtag.TMS      = tms_q;
    assign io_jtag.TDI      = tdi_q;
    assign io_jtag.TRST     = trst_q;

    assign io_pins_TDO_o_oval = tdo_oval_q;
    assign io_pins_TDO_o_oe   = tdo_oe_q;
    assign io_pins_TDO_o_ie   = 1'b0;
    assign io_pins_TDO_o_pue  = 1'b0;
    assign io_pins_TDO_o_ds   = 1'b0;

    assign io_pins_in_o_oval = 4'h0;
    assign io_pins_in_o_oe   = 4'h0;
    assign io_pins_in_o_ie   = 4'hF;
    assign io_pins_in_o_pue  = 4'hF;
    assign io_pins_in_o_ds   = 4'h0;

endmodule

// File: doc/jtag_gpio_sampler.md
Name: jtag_gpio_sampler

Overview:
Next-generation JTAG pin adapter. It oversamples the raw JTAG pads on the system clock instead of passing TCK straight through as a clock. Pad inputs are synchronised and TCK is glitch-filtered, giving one-cycle TCK rise/fall strobes for a clock-enabled TAP. TDO launch is registered on the TCK falling strobe, and TRST is stretched. It sits between the GPIO pad cells and the debug TAP.

Parameters:
SYNC_STAGES, 2, flops per pad synchroniser (>=2)
FILTER_LEN, 3, consecutive post-sync cycles TCK must differ from the filtered level before it is accepted (>=1)
TRST_HOLD, 4, cycles io_jtag_TRST stays high after the TRST_n release (>=1)

Ports:
clock  in  1  system clock
reset  in  1  synchronous, active-high
io_pins_TCK_i_ival  in  1  raw TCK pad
io_pins_TMS_i_ival  in  1  raw TMS pad
io_pins_TDI_i_ival  in  1  raw TDI pad
io_pins_TRST_n_i_ival  in  1  raw TRST_n pad, active-low
io_pins_in_o_oval  out  4  pad oval for {TRST_n,TDI,TMS,TCK}; constant 0
io_pins_in_o_oe  out  4  constant 0
io_pins_in_o_ie  out  4  constant 4'hF
io_pins_in_o_pue  out  4  constant 4'hF
io_pins_in_o_ds  out  4  constant 0
io_pins_TDO_o_oval  out  1  registered TDO
io_pins_TDO_o_oe  out  1  registered TDO drive enable
io_pins_TDO_o_ie/_pue/_ds  out  1 each  constant 0
io_jtag_tck_rise  out  1  one-cycle strobe on accepted TCK 0->1
io_jtag_tck_fall  out  1  one-cycle strobe on accepted TCK 1->0
io_jtag_TMS  out  1  TMS captured at the rise strobe
io_jtag_TDI  out  1  TDI captured at the rise strobe
io_jtag_TRST  out  1  stretched TAP reset, active-high
io_jtag_TDO  in  1  TAP serial out
io_jtag_DRV_TDO  in  1  TAP output enable

Behaviour:
- Synchronisers: SYNC_STAGES-deep chains. Reset values: TCK 0, TMS 1, TDI 1, TRST_n 1.
- TCK filter: register tck_filt (reset 0) and counter cnt (reset 0, width clog2(FILTER_LEN+1)).
  - If sync_tck == tck_filt: cnt <= 0.
  - Else if cnt == FILTER_LEN-1: tck_filt toggles and cnt <= 0.
  - Else: cnt++.
- Strobes are registered.
  - tck_rise is high for exactly the cycle after tck_filt goes 0->1; tck_fall likewise for 1->0. Both reset to 0 and are never high together.
  - Latency: a pad level first sampled at clock edge 1 produces a strobe high after edge SYNC_STAGES+FILTER_LEN (default: 5).
  - A post-sync pulse shorter than FILTER_LEN cycles is rejected: no strobe, tck_filt unchanged.
- io_jtag_TMS and io_jtag_TDI (reset 1) load the synced TMS/TDI on the same edge that raises tck_rise. They hold otherwise.
- TRST: hold counter (reset TRST_HOLD). io_jtag_TRST (reset 1) = (sync_trst_n == 0) | (hold != 0).
  - While sync_trst_n == 0, hold <= TRST_HOLD; otherwise, if nonzero, hold decrements.
  - After reset, or after TRST_n is released, io_jtag_TRST therefore stays high exactly TRST_HOLD cycles.
- While io_jtag_TRST is high, both strobes are forced to 0. tck_filt and cnt keep tracking, so no stale strobe fires on release.
- TDO path: io_pins_TDO_o_oval and io_pins_TDO_o_oe (reset 0) load io_jtag_TDO and io_jtag_DRV_TDO in the cycle tck_fall is high; otherwise they hold. io_pins_TDO_o_oe is forced to 0 while io_jtag_TRST is high.
- Assertion of reset mid-transfer: all state returns to reset values on the next edge; no partial strobe is emitted.

Optional Feature:
Macro JTAG_GPIO_GLITCH_CNT_EN.
- Defined: adds output io_glitch_cnt [7:0]. It is an 8-bit saturating counter (reset 0) that increments whenever sync_tck returns equal to tck_filt while cnt != 0, i.e. a rejected glitch. It holds at 8'hFF.
- Undefined: the port and logic are absent; behaviour is otherwise identical.

Test Plan:
- Reset release, all pads idle (TRST_n=1) -> io_jtag_TRST high exactly 4 cycles, then 0; strobes 0; TDO oe/oval 0; constant pad controls as specified.
- TCK driven high and held, with TMS=0 and TDI=1 -> tck_rise is a single cycle after edge 5; io_jtag_TMS=0 and io_jtag_TDI=1 from that cycle onward.
- TCK high for 2 post-sync cycles, then low -> no strobe; io_glitch_cnt = 1 when the macro is defined.
- Full TCK period (8 cycles high, 8 low), with io_jtag_TDO=1 and DRV_TDO=1 -> one rise and one fall strobe; io_pins_TDO_o_oval/oe = 1 the cycle after tck_fall.
- TRST_n pulled low for 3 cycles during TCK toggling -> io_jtag_TRST high for the low period plus 4 cycles; no strobes in that window; TDO oe 0.
- Synchronous reset asserted mid-TCK-high while cnt=1 -> next cycle all outputs at reset values; no strobe after reset drops until a fresh 5-edge qualification.
